window_correlator: RTL and testbench
====================================

# window_correlator

Downstream stage of the sliding-window buffer in the AIS frame detector. Consumes each replayed window (one beat per sample, index on `s_axis_tuser`, `s_axis_tlast` on the final sample) and correlates it against a fixed ±1 template. Emits one signed correlation value per complete window, plus a detect flag from a threshold compare with hold-off. Windows with index-sequence errors are discarded and flagged.

## Interface
- `PAR_DATA_WIDTH`, 16: sample width, signed two's complement.
- `PAR_DELAY_LEN`, 128: window length N, ≥ 2.
- `PAR_IDX_WIDTH`, 7: index width, = ceil(log2(N)).
- `PAR_TEMPLATE`, {64{2'b01}}: N-bit template; bit i applies to index i; 1 → +sample, 0 → −sample.
- `PAR_HOLDOFF`, 4: number of windows suppressed after a detect; 8-bit range, 0 disables.
- `K_ACC_WIDTH` (derived) = PAR_DATA_WIDTH + PAR_IDX_WIDTH + 1.
- `i_clk`  in  1  clock; everything on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `s_axis_tvalid`  in  1  sample beat valid. There is no ready; the block never back-pressures.
- `s_axis_tdata`  in  PAR_DATA_WIDTH  signed sample.
- `s_axis_tuser`  in  PAR_IDX_WIDTH  sample index within the window.
- `s_axis_tlast`  in  1  last sample of the window.
- `i_threshold`  in  K_ACC_WIDTH  signed detect threshold.
- `m_axis_tvalid`  out  1  one-cycle result strobe.
- `m_axis_tdata`  out  K_ACC_WIDTH  signed correlation sum.
- `m_axis_tuser`  out  1  detect flag; qualified by `m_axis_tvalid`.
- `o_seq_err`  out  1  one-cycle pulse when a window is aborted.

## Operation
- Term for each beat: t = PAR_TEMPLATE[tuser] ? +tdata : −tdata. Sign-extend to K_ACC_WIDTH before negating, so −(−2^(W−1)) is exact. No saturation is needed because the width covers N·2^(W−1).
- Beats with `s_axis_tvalid` low are ignored in every state. Gaps inside a window are legal.
- State `ST_SYNC` (reset state):
  - A valid beat with tuser==0 and tlast==0 sets acc ← t, expect ← 1, and moves to `ST_ACC`.
  - Any other valid beat is dropped silently.
- State `ST_ACC`, on each valid beat:
  - tuser≠expect: pulse `o_seq_err`, drop the beat and the window, go to `ST_SYNC`.
  - tuser==expect, tlast==0, expect≠N−1: acc ← acc+t, expect ← expect+1.
  - tuser==expect==N−1 with tlast==1: acc_final ← acc+t, raise internal strobe, go to `ST_SYNC`.
  - tlast==1 at any other index, or tlast==0 at index N−1: pulse `o_seq_err`, abort, go to `ST_SYNC`.
- Back-to-back windows: an index-0 beat in the cycle right after a tlast beat must be accepted. `acc_final` is a separate register from `acc`, so a new window never corrupts the pending result.
- Compare stage (the cycle after the strobe):
  - m_axis_tdata ← acc_final.
  - m_axis_tuser ← (acc_final ≥ i_threshold, signed) && (holdoff==0).
  - m_axis_tvalid ← 1.
- Hold-off, updated only on result cycles:
  - On a detect: holdoff ← PAR_HOLDOFF.
  - Otherwise, if holdoff≠0: holdoff ← holdoff−1.
  - A suppressed window still outputs its value, with tuser=0.
- Reset mid-window: the partial window is lost and no output or error is produced. The next window is accepted from its index-0 beat.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tuser`=0, `o_seq_err`=0. Internally: state=`ST_SYNC`, acc=0, acc_final=0, holdoff=0.
- Latency: tlast beat sampled at the end of cycle c → `m_axis_tvalid` high for exactly cycle c+2.
- `i_threshold` is sampled in cycle c+1.
- `o_seq_err` is high in cycle c+1 for an offending beat in cycle c.
- `m_axis_tdata` and `m_axis_tuser` hold their values between strobes.
- Throughput: one beat per cycle, sustained, with no bubbles required between windows.

## Test plan
Bench configuration: W=8, N=8, IDX=3, ACC=12, template 8'b0101_0101 (bit0=1), PAR_HOLDOFF=2, threshold=100.
- Flat input: window with all samples 10 → tdata=0, tuser=0, output in cycle c+2 after tlast.
- Matched window: samples +20 where the template bit is 1, −20 where it is 0 → tdata=160, tuser=1.
- Hold-off: five matched windows back-to-back, no gaps → tuser 1,0,0,1,0; tdata=160 on each; five strobes spaced exactly 8 cycles apart.
- Extreme values: template all-0 with all samples −128 → tdata=+1024. Template all-1 with all samples −128 → tdata=−1024, tuser=0.
- Sequence error: a window whose indices go 0,1,2,4 → `o_seq_err` pulses once and there is no result. The following correct matched window → 160/1. A window with tlast at index 5 → error, no result.
- Reset and gaps: assert `i_rst` for 1 cycle after index 3 of a window → no output and no error; the next window is correct. A matched window with valid low for 3 cycles between beats → 160/1.

Source files
------------

// File: rtl/window_correlator.sv
// Correlates each replayed sliding window against a fixed +/-1 template and
// emits one signed sum per complete window, with a hold-off-gated threshold detect.
module window_correlator #(
    parameter int                          PAR_DATA_WIDTH = 16,
    parameter int                          PAR_DELAY_LEN  = 128,
    parameter int                          PAR_IDX_WIDTH  = 7,
    parameter logic [PAR_DELAY_LEN-1:0]    PAR_TEMPLATE   = {64{2'b01}},
    parameter int                          PAR_HOLDOFF    = 4,
    localparam int                         K_ACC_WIDTH    = PAR_DATA_WIDTH + PAR_IDX_WIDTH + 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           s_axis_tvalid,
    input  logic [PAR_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [PAR_IDX_WIDTH-1:0]       s_axis_tuser,
    input  logic                           s_axis_tlast,
    input  logic [K_ACC_WIDTH-1:0]         i_threshold,
    output logic                           m_axis_tvalid,
    output logic [K_ACC_WIDTH-1:0]         m_axis_tdata,
    output logic                           m_axis_tuser,
    output logic                           o_seq_err
);

    localparam logic [PAR_IDX_WIDTH-1:0] K_IDX_LAST = PAR_IDX_WIDTH'(PAR_DELAY_LEN - 1);
    localparam logic [PAR_IDX_WIDTH-1:0] K_IDX_ZERO = {PAR_IDX_WIDTH{1'b0}};
    localparam logic [PAR_IDX_WIDTH-1:0] K_IDX_ONE  = PAR_IDX_WIDTH'(1);
    localparam logic [7:0]               K_HOLDOFF  = 8'(PAR_HOLDOFF);

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic signed [K_ACC_WIDTH-1:0]   r_acc;
    logic signed [K_ACC_WIDTH-1:0]   w_acc_nxt;
    logic signed [K_ACC_WIDTH-1:0]   r_acc_final;
    logic signed [K_ACC_WIDTH-1:0]   w_acc_final_nxt;
    logic [PAR_IDX_WIDTH-1:0]        r_expect;
    logic [PAR_IDX_WIDTH-1:0]        w_expect_nxt;
    logic                            r_strobe;
    logic                            w_strobe_nxt;
    logic                            w_err_nxt;
    logic [7:0]                      r_holdoff;
    logic signed [K_ACC_WIDTH-1:0]   w_ext;
    logic signed [K_ACC_WIDTH-1:0]   w_term;
    logic                            w_detect;

    // Sign-extend before negating so the most negative sample negates exactly.
    assign w_ext    = {{(K_ACC_WIDTH-PAR_DATA_WIDTH){s_axis_tdata[PAR_DATA_WIDTH-1]}}, s_axis_tdata};
    assign w_term   = PAR_TEMPLATE[s_axis_tuser] ? w_ext : ({K_ACC_WIDTH{1'b0}} - w_ext);
    assign w_detect = ($signed(r_acc_final) >= $signed(i_threshold)) && (r_holdoff == 8'd0);

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_acc_final_nxt = r_acc_final;
        w_expect_nxt    = r_expect;
        w_strobe_nxt    = 1'b0;
        w_err_nxt       = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (s_axis_tvalid && (s_axis_tuser == K_IDX_ZERO) && !s_axis_tlast) begin
                    w_acc_nxt    = w_term;
                    w_expect_nxt = K_IDX_ONE;
                    w_state_nxt  = ST_ACC;
                end else begin
                    w_state_nxt  = ST_SYNC;
                end
            end
            ST_ACC: begin
                if (!s_axis_tvalid) begin
                    w_state_nxt = ST_ACC;
                end else if (s_axis_tuser != r_expect) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_SYNC;
                end else if (s_axis_tlast && (r_expect == K_IDX_LAST)) begin
                    w_acc_final_nxt = r_acc + w_term;
                    w_strobe_nxt    = 1'b1;
                    w_state_nxt     = ST_SYNC;
                end else if (!s_axis_tlast && (r_expect != K_IDX_LAST)) begin
                    w_acc_nxt    = r_acc + w_term;
                    w_expect_nxt = r_expect + K_IDX_ONE;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_SYNC;
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    // Window accumulation state; acc_final is kept apart so a new window cannot disturb it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_SYNC;
            r_acc       <= {K_ACC_WIDTH{1'b0}};
            r_acc_final <= {K_ACC_WIDTH{1'b0}};
            r_expect    <= K_IDX_ZERO;
            r_strobe    <= 1'b0;
            o_seq_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_acc_final <= w_acc_final_nxt;
            r_expect    <= w_expect_nxt;
            r_strobe    <= w_strobe_nxt;
            o_seq_err   <= w_err_nxt;
        end
    end

    // Compare stage: hold-off only advances on result cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= {K_ACC_WIDTH{1'b0}};
            m_axis_tuser  <= 1'b0;
            r_holdoff     <= 8'd0;
        end else begin
            m_axis_tvalid <= r_strobe;
            if (r_strobe) begin
                m_axis_tdata <= r_acc_final;
                m_axis_tuser <= w_detect;
                if (w_detect) begin
                    r_holdoff <= K_HOLDOFF;
                end else if (r_holdoff != 8'd0) begin
                    r_holdoff <= r_holdoff - 8'd1;
                end else begin
                    r_holdoff <= r_holdoff;
                end
            end else begin
                m_axis_tdata <= m_axis_tdata;
                m_axis_tuser <= m_axis_tuser;
                r_holdoff    <= r_holdoff;
            end
        end
    end

endmodule

// File: tb/tb_window_correlator.sv
// Scoreboard bench: three correlators (alternating, all-0 and all-1 templates) share
// one stimulus stream; only the selected instance sees valid beats.
module tb_window_correlator;

    localparam logic [7:0] TMPL = 8'b0101_0101;

    typedef struct {
        int id;
        int data;
        int user;
        int cyc;
    } res_t;

    typedef struct {
        int id;
        int cyc;
    } err_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [7:0]  tdata;
    logic [2:0]  tuser;
    logic        tlast;
    logic [11:0] thr;
    int          sel;

    logic [2:0]  w_mv;
    logic [11:0] w_md [3];
    logic [2:0]  w_mu;
    logic [2:0]  w_err;

    int   cyc = 0;
    int   last_cyc = 0;
    int   checks = 0;
    int   errors = 0;
    res_t q_res[$];
    err_t q_err[$];
    res_t e;
    err_t ee;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    window_correlator #(
        .PAR_DATA_WIDTH(8), .PAR_DELAY_LEN(8), .PAR_IDX_WIDTH(3),
        .PAR_TEMPLATE(TMPL), .PAR_HOLDOFF(2)
    ) u_dut0 (
        .i_clk(clk), .i_rst(rst),
        .s_axis_tvalid(vld && (sel == 0)), .s_axis_tdata(tdata),
        .s_axis_tuser(tuser), .s_axis_tlast(tlast), .i_threshold(thr),
        .m_axis_tvalid(w_mv[0]), .m_axis_tdata(w_md[0]),
        .m_axis_tuser(w_mu[0]), .o_seq_err(w_err[0])
    );

    window_correlator #(
        .PAR_DATA_WIDTH(8), .PAR_DELAY_LEN(8), .PAR_IDX_WIDTH(3),
        .PAR_TEMPLATE(8'h00), .PAR_HOLDOFF(2)
    ) u_dut1 (
        .i_clk(clk), .i_rst(rst),
        .s_axis_tvalid(vld && (sel == 1)), .s_axis_tdata(tdata),
        .s_axis_tuser(tuser), .s_axis_tlast(tlast), .i_threshold(thr),
        .m_axis_tvalid(w_mv[1]), .m_axis_tdata(w_md[1]),
        .m_axis_tuser(w_mu[1]), .o_seq_err(w_err[1])
    );

    window_correlator #(
        .PAR_DATA_WIDTH(8), .PAR_DELAY_LEN(8), .PAR_IDX_WIDTH(3),
        .PAR_TEMPLATE(8'hFF), .PAR_HOLDOFF(2)
    ) u_dut2 (
        .i_clk(clk), .i_rst(rst),
        .s_axis_tvalid(vld && (sel == 2)), .s_axis_tdata(tdata),
        .s_axis_tuser(tuser), .s_axis_tlast(tlast), .i_threshold(thr),
        .m_axis_tvalid(w_mv[2]), .m_axis_tdata(w_md[2]),
        .m_axis_tuser(w_mu[2]), .o_seq_err(w_err[2])
    );

    // Monitor: every result strobe and error pulse must match the head of its queue.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (w_mv[k] === 1'b1) begin
                checks++;
                if (q_res.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result dut%0d cyc=%0d data=%0d user=%0b, required none",
                             k, cyc, $signed(w_md[k]), w_mu[k]);
                end else begin
                    e = q_res.pop_front();
                    if (e.id != k || e.data != int'($signed(w_md[k])) ||
                        e.user != int'(w_mu[k]) || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL result: got dut%0d data=%0d user=%0b cyc=%0d, required dut%0d data=%0d user=%0d cyc=%0d",
                                 k, $signed(w_md[k]), w_mu[k], cyc, e.id, e.data, e.user, e.cyc);
                    end
                end
            end
            if (w_err[k] === 1'b1) begin
                checks++;
                if (q_err.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_seq_err dut%0d cyc=%0d, required none", k, cyc);
                end else begin
                    ee = q_err.pop_front();
                    if (ee.id != k || ee.cyc != cyc) begin
                        errors++;
                        $display("FAIL seq_err: got dut%0d cyc=%0d, required dut%0d cyc=%0d",
                                 k, cyc, ee.id, ee.cyc);
                    end
                end
            end
        end
    end

    function automatic int samp(input int mode, input int i);
        case (mode)
            0:       return 10;
            1:       return TMPL[i] ? 20 : -20;
            default: return -128;
        endcase
    endfunction

    task automatic beat(input int k, input int idx, input int d, input bit last);
        sel      = k;
        vld      = 1'b1;
        tdata    = d[7:0];
        tuser    = idx[2:0];
        tlast    = last;
        last_cyc = cyc;
        @(posedge clk);
        #1;
        vld   = 1'b0;
        tlast = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_res(input int k, input int d, input int u);
        res_t r;
        r.id   = k;
        r.data = d;
        r.user = u;
        r.cyc  = last_cyc + 2;
        q_res.push_back(r);
    endtask

    task automatic push_err(input int k);
        err_t r;
        r.id  = k;
        r.cyc = last_cyc + 1;
        q_err.push_back(r);
    endtask

    // Full 8-beat window; gap idle cycles are inserted between index 3 and 4.
    task automatic win(input int k, input int mode, input int gap, input int ed, input int eu);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) idle(gap);
            beat(k, i, samp(mode, i), i == 7);
        end
        push_res(k, ed, eu);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    initial begin
        rst   = 1'b1;
        vld   = 1'b0;
        tdata = 8'd0;
        tuser = 3'd0;
        tlast = 1'b0;
        thr   = 12'd100;
        sel   = 0;
        idle(3);
        for (int k = 0; k < 3; k++) begin
            chk("reset_tvalid", int'(w_mv[k]), 0);
            chk("reset_tdata", int'(w_md[k]), 0);
            chk("reset_tuser", int'(w_mu[k]), 0);
            chk("reset_seq_err", int'(w_err[k]), 0);
        end
        rst = 1'b0;
        idle(2);

        win(0, 0, 0, 0, 0);
        win(0, 1, 0, 160, 1);
        win(0, 0, 0, 0, 0);
        win(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) win(0, 1, 0, 160, (i == 0 || i == 3) ? 1 : 0);
        win(0, 0, 0, 0, 0);

        win(1, 2, 0, 1024, 1);
        win(2, 2, 0, -1024, 0);

        beat(0, 0, 20, 1'b0);
        beat(0, 1, -20, 1'b0);
        beat(0, 2, 20, 1'b0);
        beat(0, 4, 20, 1'b0);
        push_err(0);
        win(0, 1, 0, 160, 1);
        for (int i = 0; i < 6; i++) beat(0, i, samp(1, i), i == 5);
        push_err(0);

        for (int i = 0; i < 4; i++) beat(0, i, samp(1, i), 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        win(0, 1, 0, 160, 1);
        win(0, 0, 0, 0, 0);
        win(0, 0, 0, 0, 0);
        win(0, 1, 3, 160, 1);

        for (int i = 0; i < 20 && (q_res.size() != 0 || q_err.size() != 0); i++) idle(1);
        idle(4);
        chk("pending_results", q_res.size(), 0);
        chk("pending_seq_errs", q_err.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
